lifegame_window: RTL and testbench

Streaming 3x3 neighborhood generator for the Life cell-rule datapath. Accepts one frame of cells in raster order (one bit per cell, 1 = live) and emits, for every cell, the 9-bit `neighbors` window consumed by the rule blocks. Out-of-grid neighbors read as dead. It sits between the frame source and the `case_top`/`add_top` rule stage, with valid/ready handshakes on both sides.

---
 rtl/lifegame_window.sv | 175 +++++++++++++++++
 tb/tb_lifegame_window.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lifegame_window.sv
// Streaming 3x3 neighbourhood generator: raster cells in, one 9-bit window per cell out.
// Optional frame counter port enabled by defining LIFEGAME_WINDOW_PERF_EN.
module lifegame_window #(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_cell,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [8:0]                neighbors,
  output logic [$clog2(WIDTH)-1:0]  out_x,
  output logic [$clog2(HEIGHT)-1:0] out_y,
  output logic                      out_last
`ifdef LIFEGAME_WINDOW_PERF_EN
  , output logic [15:0]             frame_count
`endif
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int PW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t            state, state_nx;
  logic [XW-1:0]     in_x;
  logic [YW-1:0]     in_y;
  logic [PW-1:0]     fcnt;
  logic [WIDTH-1:0]  top, mid, cur, cur_in, bot_sel;

  logic              adv, in_fire, out_fire, load, row_end, last_row;
  logic [PW-1:0]     cx;
  logic [XW-1:0]     wx;
  logic [YW-1:0]     wy;
  logic [8:0]        win;

  // Columns cx-1, cx, cx+1 of a row, left first; out-of-grid columns read 0.
  function automatic logic [2:0] pick(input logic [WIDTH-1:0] row, input logic [PW-1:0] c);
    logic [WIDTH+1:0] p;
    p = {1'b0, row, 1'b0};
    return {p[c], p[c + PW'(1)], p[c + PW'(2)]};
  endfunction

  assign adv      = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign row_end  = in_x == XW'(WIDTH - 1);
  assign last_row = in_y == YW'(HEIGHT - 1);
  assign win      = {pick(top, cx), pick(mid, cx), pick(bot_sel, cx)};

  always_comb begin
    cur_in       = cur;
    cur_in[in_x] = in_cell;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    load     = 1'b0;
    cx       = '0;
    wx       = '0;
    wy       = '0;
    bot_sel  = cur;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_fire && in_x == '0 && in_y == YW'(1)) state_nx = RUN;
      end
      RUN: begin
        in_ready = adv;
        if (in_fire) begin
          load = 1'b1;
          if (in_x == '0) begin
            // Row wrap: finish the right-edge window of the row two above.
            cx = PW'(WIDTH - 1);
            wx = XW'(WIDTH - 1);
            wy = in_y - YW'(2);
          end else begin
            cx      = PW'(in_x) - PW'(1);
            wx      = in_x - XW'(1);
            wy      = in_y - YW'(1);
            bot_sel = cur_in;
          end
          if (row_end && last_row) state_nx = FLUSH;
        end
      end
      FLUSH: begin
        if (adv && fcnt <= PW'(WIDTH)) begin
          load = 1'b1;
          if (fcnt == '0) begin
            cx = PW'(WIDTH - 1);
            wx = XW'(WIDTH - 1);
            wy = YW'(HEIGHT - 2);
          end else begin
            // Buffers have been shifted up, cur holds the zero row below the grid.
            cx = fcnt - PW'(1);
            wx = XW'(fcnt - PW'(1));
            wy = YW'(HEIGHT - 1);
          end
        end
        if (out_fire && out_last) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // Input position and line buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_x <= '0;
      in_y <= '0;
      top  <= '0;
      mid  <= '0;
      cur  <= '0;
    end else if (in_fire) begin
      cur[in_x] <= in_cell;
      if (in_x == '0) begin
        top <= (in_y == YW'(1)) ? '0 : mid;
        mid <= cur;
      end
      if (row_end) begin
        in_x <= '0;
        in_y <= last_row ? '0 : in_y + YW'(1);
      end else begin
        in_x <= in_x + XW'(1);
      end
    end else if (state == FLUSH && load && fcnt == '0) begin
      top <= mid;
      mid <= cur;
      cur <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           fcnt <= '0;
    else if (state == FLUSH && state_nx == FILL) fcnt <= '0;
    else if (state == FLUSH && load)      fcnt <= fcnt + PW'(1);
  end

  // Output register: reloaded directly on a new window, no bubble under back-to-back transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      neighbors <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      neighbors <= win;
      out_x     <= wx;
      out_y     <= wy;
      out_last  <= (wx == XW'(WIDTH - 1)) && (wy == YW'(HEIGHT - 1));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LIFEGAME_WINDOW_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    frame_count <= '0;
    else if (out_fire && out_last) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lifegame_window.sv
// Bench for lifegame_window on a 4x4 grid: directed and random frames against a cell-rule model.
module tb_lifegame_window;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk, rst_n;
  logic       in_valid, in_ready, in_cell;
  logic       out_valid, out_ready;
  logic [8:0] neighbors;
  logic [1:0] out_x, out_y;
  logic       out_last;
`ifdef LIFEGAME_WINDOW_PERF_EN
  logic [15:0] frame_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;
  bit g [H][W];

  lifegame_window #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cell(in_cell),
    .out_valid(out_valid), .out_ready(out_ready),
    .neighbors(neighbors), .out_x(out_x), .out_y(out_y), .out_last(out_last)
`ifdef LIFEGAME_WINDOW_PERF_EN
    , .frame_count(frame_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Window for cell (x,y): bit 8 is top-left neighbour, bit 0 bottom-right; off-grid reads 0.
  function automatic logic [8:0] model_win(input int x, input int y);
    logic [8:0] w;
    w = '0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        int xx, yy;
        xx = x + dx;
        yy = y + dy;
        if (xx >= 0 && xx < W && yy >= 0 && yy < H && g[yy][xx])
          w = w | (9'd1 << (8 - ((dy + 1) * 3 + (dx + 1))));
      end
    return w;
  endfunction

  task automatic check_reset_state();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_neighbors", 32'(neighbors), 0);
    chk("rst_out_xy", {out_x, out_y}, 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
`ifdef LIFEGAME_WINDOW_PERF_EN
    chk("rst_frame_count", 32'(frame_count), 0);
`endif
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_cell  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    exp_fc = 0;
    @(negedge clk);
    check_reset_state();
  endtask

  // One full frame; called at a negedge. Inputs driven at negedge, outputs sampled 1ns later.
  task automatic run_frame(input bit rnd_v, input bit rnd_r, input int stall_at);
    int n_in, n_out, cyc;
    bit held, seen;
    logic [14:0] h_fields;
    logic exp_rdy;
    n_in = 0; n_out = 0; cyc = 0; held = 0; seen = 0; h_fields = '0;
    while (n_out < N && cyc < 2000) begin
      out_ready = rnd_r ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5) out_ready = 1'b0;
      in_valid = (n_in < N) && (rnd_v ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_cell  = (n_in < N) ? g[n_in / W][n_in % W] : 1'b0;
      #1;
      if (n_in <= W)       exp_rdy = 1'b1;
      else if (n_in == N)  exp_rdy = 1'b0;
      else                 exp_rdy = !out_valid || out_ready;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (held) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_fields", {neighbors, out_x, out_y, out_last}, 32'(h_fields));
      end
      if (out_valid && !seen) begin
        seen = 1;
        chk("first_latency_inputs", n_in, W + 2);
      end
      if (out_valid && out_ready) begin
        int ex, ey;
        ex = n_out % W;
        ey = n_out / W;
        chk("window", {neighbors, out_x, out_y, out_last},
            {model_win(ex, ey), 2'(ex), 2'(ey), 1'(n_out == N - 1)});
        n_out++;
        if (n_out == N) exp_fc = (exp_fc + 1) % 65536;
      end
      held = out_valid && !out_ready;
      h_fields = {neighbors, out_x, out_y, out_last};
      if (in_valid && in_ready) n_in++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("frame_outputs_complete", n_out, N);
`ifdef LIFEGAME_WINDOW_PERF_EN
    chk("frame_count", 32'(frame_count), 32'(exp_fc));
`endif
  endtask

  task automatic fill_grid(input int kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        case (kind)
          0: g[y][x] = 1'b0;
          1: g[y][x] = (x == 1 && y == 1);
          2: g[y][x] = 1'b1;
          default: g[y][x] = 1'(($urandom_range(0, 1)));
        endcase
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_cell = 1'b0; out_ready = 1'b1;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_state();

    fill_grid(0); run_frame(0, 0, -1);
    fill_grid(1); run_frame(0, 0, -1);
    chk("single_1_1", 32'(model_win(1, 1)), 32'h010);
    fill_grid(2); run_frame(0, 0, -1);
    chk("ones_corner", 32'(model_win(3, 3)), 32'h1B0);
    fill_grid(2); run_frame(0, 0, 9);
    for (int i = 0; i < 4; i++) begin
      fill_grid(3);
      run_frame(1, 1, (i == 0) ? 10 : -1);
    end

    // Abort after 7 inputs, then a clean all-ones frame.
    fill_grid(3);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_cell  = g[i / W][i % W];
      @(negedge clk);
    end
    do_reset();
    fill_grid(2); run_frame(0, 0, -1);
    fill_grid(3); run_frame(1, 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
